// File: rtl/core_array_rr_n.sv
// N-lane capture array: per-lane edge-detected fill into a private FIFO,
// a masked round-robin allocator picking one lane per cycle, and a shared
// PE stage that passes or accumulates the granted word into that lane's
// registered output.
module core_array_rr_n #(
  parameter int DATA_SIZE      = 8,
  parameter int NUM_CH         = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int MASK_CNT_DELAY = 1,
  parameter int ACC_MODE       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DATA_SIZE-1:0]   i_data,
  input  logic [NUM_CH-1:0]             fill,
  input  logic                          stall,
  output logic [NUM_CH*DATA_SIZE-1:0]   o_data,
  output logic [NUM_CH-1:0]             o_valid,
  output logic [NUM_CH-1:0]             full,
  output logic [NUM_CH-1:0]             ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MW = (MASK_CNT_DELAY > 0) ? $clog2(MASK_CNT_DELAY + 1) : 1;

  logic [NUM_CH-1:0]    fill_q;
  logic [NUM_CH-1:0]    push;
  logic [NUM_CH-1:0]    accept;
  logic [NUM_CH-1:0]    eligible;
  logic [NUM_CH-1:0]    grant;
  logic                 gnt_any;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        rr_ptr;
  int                   sel;

  logic [DATA_SIZE-1:0] mem      [NUM_CH][FIFO_DEPTH];
  logic [DATA_SIZE-1:0] head     [NUM_CH];
  logic [AW-1:0]        wr_ptr   [NUM_CH];
  logic [AW-1:0]        rd_ptr   [NUM_CH];
  logic [CW-1:0]        count    [NUM_CH];
  logic [MW-1:0]        mask_cnt [NUM_CH];

  // Fill strobe history for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill;
  end

  // Per-lane push, acceptance, eligibility, FIFO head and full flag.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    push     = fill & ~fill_q;
    accept   = '0;
    eligible = '0;
    full     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      head[k]     = mem[k][rd_ptr[k]];
      full[k]     = (count[k] == CW'(FIFO_DEPTH));
      // A full lane can still take a word when its head leaves at this edge.
      accept[k]   = !full[k] || grant[k];
      eligible[k] = (count[k] != '0) && (mask_cnt[k] == '0) && !stall;
    end
  end

  // Round-robin search starting at rr_ptr; first eligible lane wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_any && eligible[sel]) begin
        gnt_any    = 1'b1;
        grant[sel] = 1'b1;
        gnt_idx    = PW'(sel);
      end
    end
  end

  // Round-robin pointer moves just past the granted lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      if (int'(gnt_idx) == NUM_CH - 1) rr_ptr <= '0;
      else                             rr_ptr <= gnt_idx + PW'(1);
    end
  end

  // FIFO storage array.
  // NOTE: the data array is deliberately not reset; pointers and counts
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k] && accept[k])
        mem[k][wr_ptr[k]] <= i_data[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k] && accept[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (grant[k])             rd_ptr[k] <= rd_ptr[k] + AW'(1);
        if (push[k] && !accept[k]) ovf[k] <= 1'b1;
        case ({push[k] && accept[k], grant[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // Post-grant mask: lane sits out MASK_CNT_DELAY cycles after each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) mask_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (grant[k])                mask_cnt[k] <= MW'(MASK_CNT_DELAY);
        else if (mask_cnt[k] != '0)  mask_cnt[k] <= mask_cnt[k] - MW'(1);
      end
    end
  end

  // PE stage: pass-through or wrap-around accumulate, with a one-cycle valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_valid <= '0;
    end else begin
      o_valid <= grant;
      for (int k = 0; k < NUM_CH; k++) begin
        if (grant[k]) begin
          if (ACC_MODE != 0)
            o_data[k*DATA_SIZE +: DATA_SIZE] <= o_data[k*DATA_SIZE +: DATA_SIZE] + head[k];
          else
            o_data[k*DATA_SIZE +: DATA_SIZE] <= head[k];
        end
      end
    end
  end

endmodule
